scan_host_bridge: RTL
=====================

SCAN_HOST_BRIDGE -- requirements
Module: scan_host_bridge

Interface
REQ-001 SHALL have parameter NUM_DESIGNS, default 8: number of designs on the scan chain; valid select range is 0..NUM_DESIGNS-1.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000: maximum clk cycles allowed between command bytes.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports rx_valid  input  1, rx_data  input  8, rx_ready  output  1: host command byte stream.
REQ-006 SHALL have ports tx_valid  output  1, tx_data  output  8, tx_ready  input  1: host response byte stream.
REQ-007 SHALL have ports active_select  output  9, inputs  output  8, outputs  input  8, ready  input  1: scan controller side; ready is high for one clk at the start of each scan pass.

Function
REQ-008 A byte SHALL transfer on either stream only in a cycle where valid and ready are both high.
REQ-009 The state machine SHALL have states IDLE, ARG1, ARG2, WAIT_PASS, RESP0, RESP1.
REQ-010 rx_ready SHALL be high only in IDLE, ARG1 and ARG2; tx_valid SHALL be high only in RESP0 and RESP1.
REQ-011 Command 0xA0 SHALL take two argument bytes (hi, lo); on the lo byte: if {hi[0],lo} < NUM_DESIGNS, load active_select and respond 0xA0; otherwise keep active_select and respond 0xEE.
REQ-012 Command 0xB0 SHALL take one argument byte; on receipt: load inputs, enter WAIT_PASS, respond 0xB0 then the outputs byte once the wait completes.
REQ-013 WAIT_PASS SHALL count rising edges of ready (registered previous value) and exit after exactly 2 edges, so the returned outputs reflect the new inputs.
REQ-014 Command 0xC0 SHALL respond 0xC0 then outputs, sampled in the cycle the command byte is accepted.
REQ-015 Any other command byte SHALL respond single byte 0xEE and return to IDLE.
REQ-016 Single-byte responses SHALL use RESP0 only; two-byte responses SHALL use RESP0 then RESP1.
REQ-017 tx_data SHALL stay stable while tx_valid is high and tx_ready is low.
REQ-018 The next state after the final response byte is accepted SHALL be IDLE.
REQ-019 In ARG1/ARG2 a counter SHALL count cycles without an accepted byte; at TIMEOUT_CYCLES the command SHALL abort, respond 0xEF and leave active_select and inputs unchanged.
REQ-020 A byte accepted in the same cycle the timeout is reached SHALL take priority; no timeout SHALL occur.
REQ-021 The timeout counter SHALL reset on every accepted byte and saturate; it SHALL never wrap.
REQ-022 Ready edges SHALL be ignored outside WAIT_PASS.
REQ-023 An edge arriving in the cycle WAIT_PASS is entered SHALL NOT be counted.

Reset
REQ-024 With reset low: state IDLE, active_select 0, inputs 0, tx_valid 0, tx_data 0, rx_ready 0 (asynchronously), counters 0.
REQ-025 Reset asserted mid-command or mid-response SHALL discard the command and any pending response byte.
REQ-026 rx_ready SHALL rise the first clk after reset deasserts.

Structure
REQ-027 Command codes (0xA0, 0xB0, 0xC0), response codes (0xEE, 0xEF) and the state encoding SHALL live in a shared package, scan_pkg.
REQ-028 The timeout counter SHALL be one sub-module, scan_timeout (clear, enable, parameterised limit, expired output).

Verification
REQ-029 Send A0,00,05 -> active_select=5, response 0xA0.
REQ-030 Send A0,00,08 with NUM_DESIGNS=8 -> active_select unchanged, response 0xEE.
REQ-031 Send B0,3C with a controller model that echoes inputs -> inputs=0x3C; response B0,3C only after the second ready pulse.
REQ-032 Send A0, then idle 1000 cycles -> response 0xEF; active_select unchanged. Repeat with the byte sent on cycle 1000 -> accepted, no 0xEF.
REQ-033 Send C0 with tx_ready held low for 20 cycles -> tx_valid high and tx_data=0xC0 stable throughout, then outputs byte.
REQ-034 Assert reset during WAIT_PASS -> tx_valid=0, state IDLE, inputs=0 immediately; the next command is processed normally.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared definitions for the scan host bridge: the command and response
// byte codes and the state encoding of the host-side command FSM.
package scan_pkg;

    // Host command bytes
    localparam logic [7:0] CMD_SELECT     = 8'hA0;
    localparam logic [7:0] CMD_SET_INPUTS = 8'hB0;
    localparam logic [7:0] CMD_READ       = 8'hC0;

    // Error response bytes
    localparam logic [7:0] RSP_ERROR   = 8'hEE;
    localparam logic [7:0] RSP_TIMEOUT = 8'hEF;

    // Command FSM state encoding
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ARG1      = 3'd1;
    localparam logic [2:0] ST_ARG2      = 3'd2;
    localparam logic [2:0] ST_WAIT_PASS = 3'd3;
    localparam logic [2:0] ST_RESP0     = 3'd4;
    localparam logic [2:0] ST_RESP1     = 3'd5;

    // States in which the bridge is willing to take a host byte
    function automatic logic is_rx_state(input logic [2:0] s);
        return (s == ST_IDLE) || (s == ST_ARG1) || (s == ST_ARG2);
    endfunction

endpackage

// File: rtl/scan_timeout.sv
// Inter-byte timeout counter. Counts enabled cycles, saturates at LIMIT and
// flags the LIMIT-th consecutive enabled cycle so the caller can abort in it.
module scan_timeout #(
    parameter int LIMIT = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Expiry fires in the cycle whose idle count would reach LIMIT
    assign expired_o = enable_i && (count_q >= CW'(LIMIT - 1));

    // Next count: clear wins, otherwise step while enabled and below the cap
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != CW'(LIMIT))) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/scan_host_bridge.sv
// Host-to-scan-chain bridge. Parses a byte command stream from the host,
// drives the design select and input byte toward the scan controller and
// returns one- or two-byte responses on the host response stream.
module scan_host_bridge
    import scan_pkg::*;
#(
    parameter int NUM_DESIGNS    = 8,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic [8:0] active_select,
    output logic [7:0] inputs,
    input  logic [7:0] outputs,
    input  logic       ready
);

    logic [2:0] state_q, state_d;
    logic [7:0] cmd_q, cmd_d;
    logic       hi_bit_q, hi_bit_d;
    logic       two_byte_q, two_byte_d;
    logic [7:0] resp1_q, resp1_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic [8:0] sel_q, sel_d;
    logic [7:0] inputs_q, inputs_d;
    logic       edge_seen_q, edge_seen_d;
    logic       ready_prev_q;
    logic       rx_ready_q;

    logic rx_fire;
    logic tx_fire;
    logic ready_rise;
    logic in_arg;
    logic expired;

    assign rx_ready      = rx_ready_q;
    assign tx_valid      = (state_q == ST_RESP0) || (state_q == ST_RESP1);
    assign tx_data       = tx_data_q;
    assign active_select = sel_q;
    assign inputs        = inputs_q;

    assign rx_fire    = rx_valid && rx_ready_q;
    assign tx_fire    = tx_valid && tx_ready;
    assign ready_rise = ready && !ready_prev_q;
    assign in_arg     = (state_q == ST_ARG1) || (state_q == ST_ARG2);

    scan_timeout #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (!in_arg || rx_fire),
        .enable_i (in_arg && !rx_fire),
        .expired_o(expired)
    );

    // Command FSM: decode bytes, wait for scan passes, sequence responses
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        hi_bit_d    = hi_bit_q;
        two_byte_d  = two_byte_q;
        resp1_d     = resp1_q;
        tx_data_d   = tx_data_q;
        sel_d       = sel_q;
        inputs_d    = inputs_q;
        edge_seen_d = edge_seen_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_fire) begin
                    cmd_d = rx_data;
                    case (rx_data)
                        CMD_SELECT, CMD_SET_INPUTS: begin
                            state_d = ST_ARG1;
                        end
                        CMD_READ: begin
                            state_d    = ST_RESP0;
                            tx_data_d  = CMD_READ;
                            resp1_d    = outputs;
                            two_byte_d = 1'b1;
                        end
                        default: begin
                            state_d    = ST_RESP0;
                            tx_data_d  = RSP_ERROR;
                            two_byte_d = 1'b0;
                        end
                    endcase
                end
            end
            ST_ARG1: begin
                if (rx_fire) begin
                    if (cmd_q == CMD_SELECT) begin
                        hi_bit_d = rx_data[0];
                        state_d  = ST_ARG2;
                    end else begin
                        inputs_d    = rx_data;
                        edge_seen_d = 1'b0;
                        state_d     = ST_WAIT_PASS;
                    end
                end else if (expired) begin
                    state_d    = ST_RESP0;
                    tx_data_d  = RSP_TIMEOUT;
                    two_byte_d = 1'b0;
                end
            end
            ST_ARG2: begin
                if (rx_fire) begin
                    state_d    = ST_RESP0;
                    two_byte_d = 1'b0;
                    if (int'({hi_bit_q, rx_data}) < NUM_DESIGNS) begin
                        sel_d     = {hi_bit_q, rx_data};
                        tx_data_d = CMD_SELECT;
                    end else begin
                        tx_data_d = RSP_ERROR;
                    end
                end else if (expired) begin
                    state_d    = ST_RESP0;
                    tx_data_d  = RSP_TIMEOUT;
                    two_byte_d = 1'b0;
                end
            end
            ST_WAIT_PASS: begin
                if (ready_rise) begin
                    if (edge_seen_q) begin
                        state_d    = ST_RESP0;
                        tx_data_d  = CMD_SET_INPUTS;
                        resp1_d    = outputs;
                        two_byte_d = 1'b1;
                    end else begin
                        edge_seen_d = 1'b1;
                    end
                end
            end
            ST_RESP0: begin
                if (tx_fire) begin
                    if (two_byte_q) begin
                        tx_data_d = resp1_q;
                        state_d   = ST_RESP1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RESP1: begin
                if (tx_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; rx_ready is registered so it stays low until the first clock after reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            hi_bit_q     <= 1'b0;
            two_byte_q   <= 1'b0;
            resp1_q      <= '0;
            tx_data_q    <= '0;
            sel_q        <= '0;
            inputs_q     <= '0;
            edge_seen_q  <= 1'b0;
            ready_prev_q <= 1'b0;
            rx_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            hi_bit_q     <= hi_bit_d;
            two_byte_q   <= two_byte_d;
            resp1_q      <= resp1_d;
            tx_data_q    <= tx_data_d;
            sel_q        <= sel_d;
            inputs_q     <= inputs_d;
            edge_seen_q  <= edge_seen_d;
            ready_prev_q <= ready;
            rx_ready_q   <= is_rx_state(state_d);
        end
    end

endmodule
